// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared MDU opcodes, FSM states, default latencies and divide helpers
package mdu_pkg;

    // Opcode values shared with the decoder and hazard unit.
    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;
    localparam int MDU_CNT_W       = 16;

    // Signed divide returning {remainder, quotient}. Works on magnitudes so
    // 0x80000000 / -1 wraps to 0x80000000 instead of trapping, and the
    // remainder takes the dividend's sign. A zero divisor is replaced by 1
    // only to keep the arithmetic defined; the caller discards that result.
    function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] quo;
        logic [31:0] rem;
        mag_a = a[31] ? (~a + 32'd1) : a;
        mag_b = b[31] ? (~b + 32'd1) : b;
        if (mag_b == 32'd0) begin
            mag_b = 32'd1;
        end
        quo = mag_a / mag_b;
        rem = mag_a % mag_b;
        if (a[31] ^ b[31]) begin
            quo = ~quo + 32'd1;
        end
        if (a[31]) begin
            rem = ~rem + 32'd1;
        end
        return {rem, quo};
    endfunction

    // Unsigned divide returning {remainder, quotient}; zero divisor guarded as above.
    function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] div_b;
        div_b = (b == 32'd0) ? 32'd1 : b;
        return {a % div_b, a / div_b};
    endfunction

endpackage

// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - EX-stage to MDU interface bundle
// Signals: Start/MDUOp/A/B driven by the pipeline (master);
//          Busy/HI/LO/MDUOut driven by the MDU (slave).
interface mdu_if;
    logic        Start;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUOut;

    modport master (
        output Start, MDUOp, A, B,
        input  Busy, HI, LO, MDUOut
    );

    modport slave (
        input  Start, MDUOp, A, B,
        output Busy, HI, LO, MDUOut
    );
endinterface

// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle multiply/divide unit holding architectural HI/LO
// Ports:
//   Clk   - clock, all state on rising edge
//   Reset - synchronous active-high reset
//   bus   - mdu_if.slave: Start, MDUOp, A, B in; Busy, HI, LO, MDUOut out
// The 64-bit result is computed when the operation is accepted and held
// until the counter expires, so HI/LO change only at the commit edge.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic  Clk,
    input  logic  Reset,
    mdu_if.slave  bus
);

    mdu_state_e            r_state;
    mdu_state_e            w_next_state;
    logic [MDU_CNT_W-1:0]  r_cnt;
    logic [63:0]           r_result;
    logic                  r_commit_en;
    logic [31:0]           r_hi;
    logic [31:0]           r_lo;

    logic                  w_accept;
    logic                  w_is_long;
    logic                  w_commit;
    logic signed [63:0]    w_sa;
    logic signed [63:0]    w_sb;
    logic [63:0]           w_mul_s;
    logic [63:0]           w_mul_u;
    logic [63:0]           w_div_s;
    logic [63:0]           w_div_u;

    assign w_sa    = {{32{bus.A[31]}}, bus.A};
    assign w_sb    = {{32{bus.B[31]}}, bus.B};
    assign w_mul_s = w_sa * w_sb;
    assign w_mul_u = {32'd0, bus.A} * {32'd0, bus.B};
    assign w_div_s = div_signed(bus.A, bus.B);
    assign w_div_u = div_unsigned(bus.A, bus.B);

    // Starts are only honoured in IDLE; anything issued while busy is dropped.
    assign w_accept  = bus.Start && (r_state == ST_IDLE);
    assign w_is_long = (bus.MDUOp == MDU_MULT) || (bus.MDUOp == MDU_MULTU) ||
                       (bus.MDUOp == MDU_DIV)  || (bus.MDUOp == MDU_DIVU);

    always_comb begin
        w_next_state = r_state;
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_long) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == MDU_CNT_W'(1)) begin
                    w_commit     = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_result    <= '0;
            r_commit_en <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                case (bus.MDUOp)
                    MDU_MULT: begin
                        r_result    <= w_mul_s;
                        r_cnt       <= MDU_CNT_W'(MULT_CYCLES);
                        r_commit_en <= 1'b1;
                    end
                    MDU_MULTU: begin
                        r_result    <= w_mul_u;
                        r_cnt       <= MDU_CNT_W'(MULT_CYCLES);
                        r_commit_en <= 1'b1;
                    end
                    MDU_DIV: begin
                        r_result    <= w_div_s;
                        r_cnt       <= MDU_CNT_W'(DIV_CYCLES);
                        r_commit_en <= (bus.B != 32'd0);
                    end
                    MDU_DIVU: begin
                        r_result    <= w_div_u;
                        r_cnt       <= MDU_CNT_W'(DIV_CYCLES);
                        r_commit_en <= (bus.B != 32'd0);
                    end
                    MDU_MTHI: r_hi <= bus.A;
                    MDU_MTLO: r_lo <= bus.A;
                    default: ;
                endcase
            end else if (r_state == ST_RUN) begin
                r_cnt <= r_cnt - MDU_CNT_W'(1);
                // Divide by zero runs the full latency but leaves HI/LO alone.
                if (w_commit && r_commit_en) begin
                    r_hi <= r_result[63:32];
                    r_lo <= r_result[31:0];
                end
            end
        end
    end

    assign bus.Busy   = (r_state == ST_RUN);
    assign bus.HI     = r_hi;
    assign bus.LO     = r_lo;
    assign bus.MDUOut = (bus.MDUOp == MDU_MFHI) ? r_hi :
                        (bus.MDUOp == MDU_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - directed self-checking bench for mdu
module tb_mdu;
    import mdu_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mdu_if u_if();

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse Start for one edge, then count Busy cycles (bounded).
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cycles);
        @(negedge clk);
        u_if.Start = 1'b1; u_if.MDUOp = op; u_if.A = a; u_if.B = b;
        @(negedge clk);
        u_if.Start = 1'b0; u_if.MDUOp = MDU_NONE;
        busy_cycles = 0;
        while (u_if.Busy === 1'b1 && busy_cycles < 50) begin
            busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        u_if.Start = 1'b0; u_if.MDUOp = MDU_NONE; u_if.A = '0; u_if.B = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (u_if.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", u_if.Busy); end
        checks++; if (u_if.HI !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 0", u_if.HI); end
        checks++; if (u_if.LO !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 0", u_if.LO); end
        u_if.MDUOp = MDU_MFHI; #1;
        checks++; if (u_if.MDUOut !== 32'd0) begin errors++; $display("FAIL reset_mfhi got %h exp 0", u_if.MDUOut); end
        u_if.MDUOp = MDU_MFLO; #1;
        checks++; if (u_if.MDUOut !== 32'd0) begin errors++; $display("FAIL reset_mflo got %h exp 0", u_if.MDUOut); end
        u_if.MDUOp = MDU_NONE;
    endtask

    task automatic test_long(input string name, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input int exp_busy,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        run_op(op, a, b, n);
        checks++; if (n !== exp_busy) begin errors++; $display("FAIL %s_busy got %0d exp %0d", name, n, exp_busy); end
        checks++; if (u_if.HI !== exp_hi) begin errors++; $display("FAIL %s_hi got %h exp %h", name, u_if.HI, exp_hi); end
        checks++; if (u_if.LO !== exp_lo) begin errors++; $display("FAIL %s_lo got %h exp %h", name, u_if.LO, exp_lo); end
        u_if.MDUOp = MDU_MFHI; #1;
        checks++; if (u_if.MDUOut !== exp_hi) begin errors++; $display("FAIL %s_mfhi got %h exp %h", name, u_if.MDUOut, exp_hi); end
        u_if.MDUOp = MDU_MFLO; #1;
        checks++; if (u_if.MDUOut !== exp_lo) begin errors++; $display("FAIL %s_mflo got %h exp %h", name, u_if.MDUOut, exp_lo); end
        u_if.MDUOp = MDU_NONE;
    endtask

    task automatic test_mt;
        int n;
        run_op(MDU_MTHI, 32'h12345678, 32'h0, n);
        checks++; if (n !== 0) begin errors++; $display("FAIL mthi_busy got %0d exp 0", n); end
        checks++; if (u_if.HI !== 32'h12345678) begin errors++; $display("FAIL mthi_hi got %h exp 12345678", u_if.HI); end
        checks++; if (u_if.LO !== 32'd3) begin errors++; $display("FAIL mthi_lo got %h exp 3", u_if.LO); end
        run_op(MDU_MTLO, 32'h9ABCDEF0, 32'h0, n);
        checks++; if (u_if.LO !== 32'h9ABCDEF0) begin errors++; $display("FAIL mtlo_lo got %h exp 9abcdef0", u_if.LO); end
        checks++; if (u_if.HI !== 32'h12345678) begin errors++; $display("FAIL mtlo_hi got %h exp 12345678", u_if.HI); end
        // Unknown opcode and MFHI with Start must leave everything alone.
        run_op(4'hF, 32'hDEADBEEF, 32'h1, n);
        run_op(MDU_MFHI, 32'hDEADBEEF, 32'h1, n);
        checks++; if (n !== 0 || u_if.HI !== 32'h12345678 || u_if.LO !== 32'h9ABCDEF0) begin
            errors++; $display("FAIL nop_ops got busy %0d hi %h lo %h exp 0 12345678 9abcdef0", n, u_if.HI, u_if.LO);
        end
    endtask

    task automatic test_ignored_start;
        int n;
        @(negedge clk);
        u_if.Start = 1'b1; u_if.MDUOp = MDU_MULT; u_if.A = 32'h00010000; u_if.B = 32'h00010000;
        @(negedge clk);
        u_if.Start = 1'b0; u_if.MDUOp = MDU_NONE;
        n = 1;                                   // in busy cycle 1
        @(negedge clk); n++;                     // busy cycle 2: issue DIV
        u_if.Start = 1'b1; u_if.MDUOp = MDU_DIV; u_if.A = 32'd100; u_if.B = 32'd3;
        @(negedge clk); n++;
        u_if.Start = 1'b0; u_if.MDUOp = MDU_NONE;
        while (u_if.Busy === 1'b1 && n < 50) begin
            @(negedge clk);
            if (u_if.Busy === 1'b1) n++;
        end
        checks++; if (n !== 5) begin errors++; $display("FAIL ign_busy got %0d exp 5", n); end
        checks++; if (u_if.HI !== 32'd1 || u_if.LO !== 32'd0) begin
            errors++; $display("FAIL ign_result got hi %h lo %h exp 1 0", u_if.HI, u_if.LO);
        end
        repeat (12) @(negedge clk);
        checks++; if (u_if.Busy !== 1'b0 || u_if.HI !== 32'd1 || u_if.LO !== 32'd0) begin
            errors++; $display("FAIL ign_later got busy %0b hi %h lo %h exp 0 1 0", u_if.Busy, u_if.HI, u_if.LO);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        u_if.Start = 1'b1; u_if.MDUOp = MDU_MULT; u_if.A = 32'd5; u_if.B = 32'd7;
        @(negedge clk);
        u_if.Start = 1'b0; u_if.MDUOp = MDU_NONE;
        @(negedge clk);
        @(negedge clk);                          // busy cycle 3
        checks++; if (u_if.Busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before got %0b exp 1", u_if.Busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (u_if.Busy !== 1'b0 || u_if.HI !== 32'd0 || u_if.LO !== 32'd0) begin
            errors++; $display("FAIL rmid_after got busy %0b hi %h lo %h exp 0 0 0", u_if.Busy, u_if.HI, u_if.LO);
        end
        repeat (10) @(negedge clk);
        checks++; if (u_if.Busy !== 1'b0 || u_if.HI !== 32'd0 || u_if.LO !== 32'd0) begin
            errors++; $display("FAIL rmid_later got busy %0b hi %h lo %h exp 0 0 0", u_if.Busy, u_if.HI, u_if.LO);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_long("mult",     MDU_MULT,  32'hFFFFFFFF, 32'd2,        5,  32'hFFFFFFFF, 32'hFFFFFFFE);
        test_long("multu",    MDU_MULTU, 32'hFFFFFFFF, 32'd2,        5,  32'h00000001, 32'hFFFFFFFE);
        test_long("mult_min", MDU_MULT,  32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000);
        test_long("div",      MDU_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        test_long("div_ovf",  MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
        test_long("divu",     MDU_DIVU,  32'd7,        32'd2,        10, 32'h00000001, 32'h00000003);
        test_long("divu_z",   MDU_DIVU,  32'd9,        32'd0,        10, 32'h00000001, 32'h00000003);
        test_long("div_z",    MDU_DIV,   32'hFFFFFF00, 32'd0,        10, 32'h00000001, 32'h00000003);
        test_mt();
        test_ignored_start();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit in the EX stage of the five-stage MIPS pipeline.
- Consumes the two register operands read from the register file (after forwarding muxes).
- Executes mult/multu/div/divu with fixed multi-cycle latency and holds architectural HI/LO.
- Serves mfhi/mflo/mthi/mtlo. Raises Busy so the hazard unit can stall dependent MD instructions in ID.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for mult/multu (must be >= 1).
- DIV_CYCLES, 10, cycles Busy stays high for div/divu (must be >= 1).

Ports:
- Clk  input  1  system clock, all state on rising edge.
- Reset  input  1  synchronous active-high reset.
- Start  input  1  one-cycle pulse, qualifies MDUOp for mult/multu/div/divu/mthi/mtlo.
- MDUOp  input  4  operation code (constants in macro.v).
- A  input  32  operand rs (forwarded GRF RD1).
- B  input  32  operand rt (forwarded GRF RD2).
- Busy  output  1  long operation in flight.
- HI  output  32  current HI register.
- LO  output  32  current LO register.
- MDUOut  output  32  HI when MDUOp=MFHI, LO when MDUOp=MFLO, else 0. Combinational.

Behaviour:
- Clock and reset: one clock (Clk); reset is synchronous and active-high (Reset).
- Reset values: HI=0, LO=0, Busy=0, internal counter=0, latched result=0.
- Reset mid-operation: the pending result is discarded. Busy is 0 and HI/LO are 0 after that edge.
- States: IDLE (Busy=0), RUN (Busy=1, counter counting down).
- IDLE, Start with MULT/MULTU/DIV/DIVU at edge k:
  - Compute the 64-bit result from A and B sampled at edge k and latch it.
  - Load counter with MULT_CYCLES or DIV_CYCLES and go to RUN.
  - Busy=1 for cycles k+1 .. k+N.
- RUN: counter decrements each edge.
  - At the edge where counter==1: commit latched result to HI/LO, clear Busy, go to IDLE.
  - The new HI/LO are visible in the same cycle Busy falls.
  - Busy is high for exactly N cycles.
- IDLE, Start with MTHI/MTLO: HI<=A (or LO<=A) at that edge, no Busy.
- Start while Busy=1: ignored entirely, no latch and no HI/LO change. The hazard unit guarantees none are issued; the verifier checks that they are ignored.
- Start with MFHI/MFLO or an unknown op: no state change.
- Start and commit at the same edge cannot occur, because Busy was still 1 at that edge.
- MULT (signed): {HI,LO} = $signed(A) * $signed(B), full 64-bit.
- MULTU: {HI,LO} = A * B unsigned, full 64-bit.
- DIV (signed):
  - LO = quotient truncated toward zero.
  - HI = remainder, with the sign of the dividend.
  - 0x80000000 / -1 gives LO=0x80000000, HI=0.
- DIVU: LO = A / B, HI = A % B, unsigned.
- Divide by zero (B==0, div or divu): Busy still runs DIV_CYCLES. HI/LO are left unchanged at commit.
- MDUOut reflects the HI/LO registers only. A commit or mt* appears on MDUOut in the cycle after the edge, with no bypass.

Decomposition:
- macro.v gains MDUOp constants: MDU_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8.
- macro.v also gains the default latencies.
- The hazard unit and decoder share these constants.
- Single module, no sub-module; the datapath is small enough to stay flat.

Test Plan:
- Reset, then idle 3 cycles -> HI=0, LO=0, Busy=0, MDUOut=0 for MFHI and MFLO.
- MULT with A=0xFFFFFFFF, B=2 -> Busy high exactly 5 cycles. On the falling cycle HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU with A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- DIV with A=0xFFFFFFF9 (-7), B=2 -> Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7/2 -> LO=3, HI=1.
- DIVU by B=0 after HI=1, LO=3 -> Busy 10 cycles, HI/LO stay 1/3.
- MTHI A=0x12345678 -> next cycle HI=0x12345678, Busy never 1.
- MULT start, then a DIV Start pulse at cycle 2 of Busy -> ignored, MULT result commits at cycle 5.
- MULT start, Reset at cycle 3 -> Busy=0, HI=LO=0 next cycle, no later commit.
